gate_bist_checker: RTL and testbench
====================================

Name: gate_bist_checker

Overview:
- Self-test controller for the XOR/XOR/NOT/AND gate block.
- Generates every 3-bit input vector on a/b/c, waits for the outputs to settle, then samples d/e/f/y.
- Compares the samples against a golden model and reports a mismatch count, the first failing vector, and pass/fail.
- It is the consuming end of the gate interface: it drives what the gate block reads and checks what the gate block produces.

Parameters:
- SETTLE_CYCLES, 1: cycles between the stimulus change and response sampling; legal range 1..15.
- SWEEPS, 1: number of full 0..7 vector sweeps per run; legal range 1..15.
- CNT_W, 5: width of the error counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a run; accepted only in IDLE or DONE.
- stim_a  out  1  stimulus to gate input a.
- stim_b  out  1  stimulus to gate input b.
- stim_c  out  1  stimulus to gate input c.
- resp_d  in  1  gate XOR output.
- resp_e  in  1  gate second-XOR output.
- resp_f  in  1  gate NOT output.
- resp_y  in  1  gate AND output.
- busy  out  1  high while a run is in progress.
- done  out  1  high from run completion until the next accepted start.
- pass  out  1  equals done AND (err_count == 0).
- err_count  out  CNT_W  number of mismatching vector checks; saturates at all-ones.
- first_fail_vec  out  3  {a,b,c} of the first mismatching check.
- first_fail_valid  out  1  high once first_fail_vec has been captured.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; stim_a/b/c=0; busy=0; done=0; pass=0; err_count=0; first_fail_vec=0; first_fail_valid=0; internal vector, sweep and settle counters=0.
- Reset asserted mid-run aborts immediately to these values; no partial result is kept.
- Golden model, held as a package function:
  - d = a^b
  - e = a^b^c
  - f = ~(a^b^c)
  - y = a&b&c
  - A check mismatches if any of the four response bits differs.
- FSM states: IDLE, DRIVE, SETTLE, CHECK, DONE.
- IDLE or DONE with start=1 → DRIVE.
  - On that edge: vector=0, sweep=0, err_count=0, first_fail_valid=0, first_fail_vec=0, done=0, busy=1.
- DRIVE (1 cycle):
  - {stim_a,stim_b,stim_c} are registered from the vector on entry and stay stable until the next DRIVE.
  - → SETTLE with settle counter=0.
- SETTLE: counts SETTLE_CYCLES cycles, then → CHECK.
- CHECK (1 cycle):
  - Samples resp_* and compares them against the golden model of the current vector.
  - On mismatch: err_count increments, saturating at 2^CNT_W−1.
  - On mismatch with first_fail_valid=0: capture the vector and set first_fail_valid=1.
  - If vector==7 and sweep==SWEEPS−1: → DONE.
  - Otherwise → DRIVE; the vector increments modulo 8, and sweep increments when the vector wraps 7→0.
- DONE: busy=0, done=1. Stimulus holds the last vector (7). All results hold until the next start.
- start while busy is ignored.
- Latency per vector is SETTLE_CYCLES+2 cycles. Run length is 8·SWEEPS·(SETTLE_CYCLES+2) cycles, measured from the start-accepting edge to the edge that sets done (24 cycles at defaults).
- Stimulus bit order: a = vector[2], b = vector[1], c = vector[0].
- resp_* are treated as synchronous to clk; no synchronizers.

Decomposition:
- Shared package gate_bist_pkg:
  - FSM state enum.
  - golden function (3-bit vector → 4-bit {d,e,f,y}).
  - NUM_VECTORS=8 constant.
- One natural sub-module: gate_bist_golden, the combinational golden model wrapping the package function, reused by the bench scoreboard.
- The FSM and counters stay in gate_bist_checker.

Test Plan:
1. Correct gate instance in loop, defaults, pulse start → done rises exactly 24 cycles after the start edge; err_count=0; pass=1; first_fail_valid=0.
2. Stuck-at-0 injected on resp_y → err_count=1; first_fail_vec=3'b111; pass=0.
3. resp_f inverted, SWEEPS=2 → err_count=16; first_fail_vec=3'b000; first_fail_valid=1.
4. CNT_W=3, all responses forced wrong, SWEEPS=2 → err_count saturates at 7 and does not wrap.
5. rst_n dropped low mid-run at vector 4 → all outputs are 0 within the same cycle (asynchronous); a new start gives a clean 24-cycle run with pass=1.
6. start pulsed again during a run → ignored, completion time unchanged. start pulsed in DONE after a failing run → results clear and a fresh run completes with pass=1.

Source files
------------

// File: rtl/gate_bist_pkg.sv
// Shared types and the golden model for the gate block self-test.
package gate_bist_pkg;

  localparam int NUM_VECTORS = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Expected gate outputs {d,e,f,y} for input vector {a,b,c}.
  function automatic logic [3:0] golden(input logic [2:0] vec);
    logic a;
    logic b;
    logic c;
    a = vec[2];
    b = vec[1];
    c = vec[0];
    return {a ^ b, a ^ b ^ c, ~(a ^ b ^ c), a & b & c};
  endfunction

endpackage

// File: rtl/gate_bist_checker_if.sv
// Stimulus/response wiring between the self-test checker and the gate block.
//
// Handshake: there is no valid/ready pair on this bus. stim_* are held stable
// by the checker from one DRIVE state to the next; resp_* are plain levels
// that the gate block produces combinationally from stim_* and that the
// checker samples once per vector, SETTLE_CYCLES after the stimulus changed.
interface gate_bist_checker_if;
  logic stim_a;
  logic stim_b;
  logic stim_c;
  logic resp_d;
  logic resp_e;
  logic resp_f;
  logic resp_y;

  // Checker side: drives stimulus, reads responses.
  modport master (
    output stim_a, stim_b, stim_c,
    input  resp_d, resp_e, resp_f, resp_y
  );

  // Gate block side: reads stimulus, drives responses.
  modport slave (
    input  stim_a, stim_b, stim_c,
    output resp_d, resp_e, resp_f, resp_y
  );
endinterface

// File: rtl/gate_bist_golden.sv
// Combinational golden model of the XOR/XOR/NOT/AND gate block.
module gate_bist_golden
  import gate_bist_pkg::*;
(
  input  logic [2:0] vec,
  output logic [3:0] resp
);

  // Expected {d,e,f,y} for the vector currently under test.
  assign resp = golden(vec);

endmodule

// File: rtl/gate_bist_checker.sv
// Self-test controller: sweeps all 3-bit vectors into the gate block, waits
// for the outputs to settle, compares them with the golden model and reports
// a saturating mismatch count, the first failing vector and pass/fail.
module gate_bist_checker
  import gate_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int SWEEPS        = 1,
  parameter int CNT_W         = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  gate_bist_checker_if.master  gif,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_W-1:0]     err_count,
  output logic [2:0]           first_fail_vec,
  output logic                 first_fail_valid,
  output state_t               dbg_state
);

  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0]       SWEEP_LAST  = 4'(SWEEPS - 1);
  localparam logic [2:0]       VEC_LAST    = 3'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0] ERR_MAX     = {CNT_W{1'b1}};

  state_t           state, state_n;
  logic [2:0]       vec, vec_n;
  logic [3:0]       sweep, sweep_n;
  logic [3:0]       settle, settle_n;
  logic [2:0]       stim, stim_n;
  logic [CNT_W-1:0] err, err_n;
  logic [2:0]       ffvec, ffvec_n;
  logic             ffv, ffv_n;

  logic [3:0]       exp_resp;
  logic [3:0]       got_resp;
  logic             mismatch;

  gate_bist_golden u_golden (
    .vec  (vec),
    .resp (exp_resp)
  );

  assign got_resp = {gif.resp_d, gif.resp_e, gif.resp_f, gif.resp_y};
  assign mismatch = (got_resp != exp_resp);

  // Next-state and next-datapath values; everything holds unless a state acts.
  always_comb begin
    state_n  = state;
    vec_n    = vec;
    sweep_n  = sweep;
    settle_n = settle;
    stim_n   = stim;
    err_n    = err;
    ffvec_n  = ffvec;
    ffv_n    = ffv;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_n  = ST_DRIVE;
          vec_n    = 3'd0;
          sweep_n  = 4'd0;
          settle_n = 4'd0;
          stim_n   = 3'd0;
          err_n    = '0;
          ffvec_n  = 3'd0;
          ffv_n    = 1'b0;
        end
      end
      ST_DRIVE: begin
        state_n  = ST_SETTLE;
        settle_n = 4'd0;
      end
      ST_SETTLE: begin
        if (settle == SETTLE_LAST) begin
          state_n = ST_CHECK;
        end else begin
          settle_n = settle + 4'd1;
        end
      end
      ST_CHECK: begin
        if (mismatch) begin
          if (err != ERR_MAX) begin
            err_n = err + 1'b1;
          end
          if (!ffv) begin
            ffvec_n = vec;
            ffv_n   = 1'b1;
          end
        end
        if (vec == VEC_LAST && sweep == SWEEP_LAST) begin
          state_n = ST_DONE;
        end else begin
          // Stimulus is loaded together with the vector so it is already
          // stable during the DRIVE cycle that follows.
          state_n = ST_DRIVE;
          vec_n   = vec + 3'd1;
          stim_n  = vec + 3'd1;
          if (vec == VEC_LAST) begin
            sweep_n = sweep + 4'd1;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any run with no partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      vec    <= 3'd0;
      sweep  <= 4'd0;
      settle <= 4'd0;
      stim   <= 3'd0;
      err    <= '0;
      ffvec  <= 3'd0;
      ffv    <= 1'b0;
    end else begin
      state  <= state_n;
      vec    <= vec_n;
      sweep  <= sweep_n;
      settle <= settle_n;
      stim   <= stim_n;
      err    <= err_n;
      ffvec  <= ffvec_n;
      ffv    <= ffv_n;
    end
  end

  assign gif.stim_a       = stim[2];
  assign gif.stim_b       = stim[1];
  assign gif.stim_c       = stim[0];
  assign busy             = (state == ST_DRIVE) || (state == ST_SETTLE) || (state == ST_CHECK);
  assign done             = (state == ST_DONE);
  assign pass             = done && (err == '0);
  assign err_count        = err;
  assign first_fail_vec   = ffvec;
  assign first_fail_valid = ffv;
  assign dbg_state        = state;

endmodule

// File: tb/tb_gate_bist_checker.sv
// Bench for gate_bist_checker: three instances (defaults, SWEEPS=2, and
// SWEEPS=2 with CNT_W=3) each looped through a gate model with selectable
// fault injection. Drivers push expected run results into per-instance
// queues; monitors pop and compare whenever done rises.
module tb_gate_bist_checker;
  import gate_bist_pkg::*;

  localparam int W = 18; // {lat[7:0], pass, ffv, ffvec[2:0], err[4:0]}

  // Fault modes for the gate model.
  localparam int M_OK   = 0; // correct gate
  localparam int M_YSA0 = 1; // y stuck at 0
  localparam int M_FINV = 2; // f inverted
  localparam int M_ALL  = 3; // every output inverted

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  int   cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs and gate models ----------------
  logic       start0, start1, start2;
  int         mode0, mode1, mode2;
  logic       busy0, busy1, busy2;
  logic       done0, done1, done2;
  logic       pass0, pass1, pass2;
  logic [4:0] err0, err1;
  logic [2:0] err2;
  logic [2:0] ffvec0, ffvec1, ffvec2;
  logic       ffv0, ffv1, ffv2;
  state_t     dbg0, dbg1, dbg2;

  gate_bist_checker_if gif0 ();
  gate_bist_checker_if gif1 ();
  gate_bist_checker_if gif2 ();

  // Independent gate behaviour: d=a^b, e=a^b^c, f=~e, y=a&b&c, then faults.
  function automatic logic [3:0] gate_model(input logic a, b, c, input int mode);
    logic d, e, f, y;
    d = a ^ b;
    e = d ^ c;
    f = ~e;
    y = a & b & c;
    case (mode)
      M_YSA0:  y = 1'b0;
      M_FINV:  f = ~f;
      M_ALL:   begin d = ~d; e = ~e; f = ~f; y = ~y; end
      default: ;
    endcase
    return {d, e, f, y};
  endfunction

  assign {gif0.resp_d, gif0.resp_e, gif0.resp_f, gif0.resp_y} =
    gate_model(gif0.stim_a, gif0.stim_b, gif0.stim_c, mode0);
  assign {gif1.resp_d, gif1.resp_e, gif1.resp_f, gif1.resp_y} =
    gate_model(gif1.stim_a, gif1.stim_b, gif1.stim_c, mode1);
  assign {gif2.resp_d, gif2.resp_e, gif2.resp_f, gif2.resp_y} =
    gate_model(gif2.stim_a, gif2.stim_b, gif2.stim_c, mode2);

  gate_bist_checker dut0 (
    .clk (clk), .rst_n (rst_n), .start (start0), .gif (gif0),
    .busy (busy0), .done (done0), .pass (pass0), .err_count (err0),
    .first_fail_vec (ffvec0), .first_fail_valid (ffv0), .dbg_state (dbg0)
  );

  gate_bist_checker #(.SWEEPS(2)) dut1 (
    .clk (clk), .rst_n (rst_n), .start (start1), .gif (gif1),
    .busy (busy1), .done (done1), .pass (pass1), .err_count (err1),
    .first_fail_vec (ffvec1), .first_fail_valid (ffv1), .dbg_state (dbg1)
  );

  gate_bist_checker #(.SWEEPS(2), .CNT_W(3)) dut2 (
    .clk (clk), .rst_n (rst_n), .start (start2), .gif (gif2),
    .busy (busy2), .done (done2), .pass (pass2), .err_count (err2),
    .first_fail_vec (ffvec2), .first_fail_valid (ffv2), .dbg_state (dbg2)
  );

  // ---------------- scoreboard ----------------
  int           n_checks;
  int           n_errors;
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_q2[$];
  int           start_cyc[3];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk_exp(input int lat, input logic pass,
                                          input logic ffv, input logic [2:0] ffvec,
                                          input int err);
    return {8'(lat), pass, ffv, ffvec, 5'(err)};
  endfunction

  task automatic check_run(input string tag, input logic [W-1:0] e, input int lat,
                           input logic pass, input logic ffv, input logic [2:0] ffvec,
                           input int err);
    chk({tag, ".latency"},   lat,   int'(e[17:10]));
    chk({tag, ".pass"},      pass,  int'(e[9]));
    chk({tag, ".ffv"},       ffv,   int'(e[8]));
    chk({tag, ".ffvec"},     ffvec, int'(e[7:5]));
    chk({tag, ".err_count"}, err,   int'(e[4:0]));
  endtask

  // ---------------- monitors ----------------
  logic done0_q, done1_q, done2_q;

  always @(negedge clk) begin
    done0_q <= done0;
    if (done0 && !done0_q) begin
      if (exp_q0.size() == 0) chk("dut0.unexpected_done", 1, 0);
      else check_run("dut0", exp_q0.pop_front(), cyc - start_cyc[0],
                     pass0, ffv0, ffvec0, int'(err0));
    end
  end

  always @(negedge clk) begin
    done1_q <= done1;
    if (done1 && !done1_q) begin
      if (exp_q1.size() == 0) chk("dut1.unexpected_done", 1, 0);
      else check_run("dut1", exp_q1.pop_front(), cyc - start_cyc[1],
                     pass1, ffv1, ffvec1, int'(err1));
    end
  end

  always @(negedge clk) begin
    done2_q <= done2;
    if (done2 && !done2_q) begin
      if (exp_q2.size() == 0) chk("dut2.unexpected_done", 1, 0);
      else check_run("dut2", exp_q2.pop_front(), cyc - start_cyc[2],
                     pass2, ffv2, ffvec2, int'(err2));
    end
  end

  // ---------------- drivers ----------------
  task automatic set_start(input int id, input logic v);
    case (id)
      0: start0 = v;
      1: start1 = v;
      default: start2 = v;
    endcase
  endtask

  // One-cycle start pulse; records the accepting edge for latency checks.
  task automatic pulse_start(input int id);
    @(negedge clk);
    set_start(id, 1'b1);
    @(posedge clk);
    #1;
    start_cyc[id] = cyc;
    @(negedge clk);
    set_start(id, 1'b0);
  endtask

  // Start pulse that should be ignored (no latency bookkeeping).
  task automatic pulse_start_raw(input int id);
    @(negedge clk);
    set_start(id, 1'b1);
    @(negedge clk);
    set_start(id, 1'b0);
  endtask

  task automatic wait_done(input int id, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      case (id)
        0: seen = done0;
        1: seen = done1;
        default: seen = done2;
      endcase
    end
    if (!seen) chk($sformatf("dut%0d.done_timeout", id), 0, 1);
    @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic found;
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    mode0 = M_OK; mode1 = M_OK; mode2 = M_OK;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    chk("reset.busy",      busy0, 0);
    chk("reset.done",      done0, 0);
    chk("reset.pass",      pass0, 0);
    chk("reset.err_count", int'(err0), 0);
    chk("reset.ffv",       ffv0, 0);
    chk("reset.stim",      int'({gif0.stim_a, gif0.stim_b, gif0.stim_c}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Correct gate, defaults: 24-cycle clean run.
    exp_q0.push_back(mk_exp(24, 1'b1, 1'b0, 3'd0, 0));
    pulse_start(0);
    chk("t1.busy_after_start", busy0, 1);
    wait_done(0, 100);

    // y stuck at 0: only vector 7 fails.
    mode0 = M_YSA0;
    exp_q0.push_back(mk_exp(24, 1'b0, 1'b1, 3'b111, 1));
    pulse_start(0);
    wait_done(0, 100);

    // Start in DONE after a failing run: results clear, fresh run passes.
    mode0 = M_OK;
    exp_q0.push_back(mk_exp(24, 1'b1, 1'b0, 3'd0, 0));
    pulse_start(0);
    chk("t6b.cleared_err",  int'(err0), 0);
    chk("t6b.cleared_ffv",  ffv0, 0);
    chk("t6b.cleared_done", done0, 0);
    wait_done(0, 100);

    // f inverted, two sweeps: all 16 checks fail.
    mode1 = M_FINV;
    exp_q1.push_back(mk_exp(48, 1'b0, 1'b1, 3'b000, 16));
    pulse_start(1);
    wait_done(1, 200);

    // CNT_W=3, everything wrong, two sweeps: count saturates at 7.
    mode2 = M_ALL;
    exp_q2.push_back(mk_exp(48, 1'b0, 1'b1, 3'b000, 7));
    pulse_start(2);
    wait_done(2, 200);

    // Reset mid-run at vector 4 (errors already accumulated).
    mode0 = M_FINV;
    pulse_start(0);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      found = ({gif0.stim_a, gif0.stim_b, gif0.stim_c} == 3'b100);
    end
    chk("t5.reached_vec4", found, 1);
    chk("t5.err_before_reset", int'(err0), 4);
    #2 rst_n = 1'b0;
    #1;
    chk("t5.busy",      busy0, 0);
    chk("t5.done",      done0, 0);
    chk("t5.pass",      pass0, 0);
    chk("t5.err_count", int'(err0), 0);
    chk("t5.ffv",       ffv0, 0);
    chk("t5.ffvec",     int'(ffvec0), 0);
    chk("t5.stim",      int'({gif0.stim_a, gif0.stim_b, gif0.stim_c}), 0);
    chk("t5.state",     int'(dbg0), int'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    mode0 = M_OK;
    exp_q0.push_back(mk_exp(24, 1'b1, 1'b0, 3'd0, 0));
    pulse_start(0);
    wait_done(0, 100);

    // start during a run is ignored; completion stays 24 cycles after first start.
    exp_q0.push_back(mk_exp(24, 1'b1, 1'b0, 3'd0, 0));
    pulse_start(0);
    repeat (8) @(negedge clk);
    pulse_start_raw(0);
    wait_done(0, 100);

    repeat (3) @(negedge clk);
    chk("end.q0_empty", exp_q0.size(), 0);
    chk("end.q1_empty", exp_q1.size(), 0);
    chk("end.q2_empty", exp_q2.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
